grf_regfile: RTL and testbench
==============================

# grf_regfile

General-purpose register file for the RV64I core: the responder to the decode stage's two register read requests, plus a write-back port. It holds 32 × 64-bit integer registers with x0 hard-wired to zero. It includes optional write-to-read bypass and a per-register busy scoreboard, so the issue logic can detect read-after-write hazards against in-flight writers. It sits between decode (read addresses in, operands out) and the write-back stage.

## Interface
Parameters:
- `BYPASS_EN`, default 1: 1 means a same-cycle write-back is forwarded to matching read ports; 0 means reads see the old value until the next cycle.
- `RESET_CLEAR`, default 1: 1 means all registers are cleared to 0 on reset; 0 means only the scoreboard is cleared.

Ports:
- `i_Clk`, in, 1: core clock. Single clock domain. One clock; all state updates on the rising edge.
- `i_Rst`, in, 1: reset. Synchronous, active-high.
- `i_GRFReadAddr1_5`, in, 5: read port 1 address (rs1 from decode).
- `i_GRFReadAddr2_5`, in, 5: read port 2 address (rs2 from decode).
- `o_GRFReadData1_64`, out, 64: read port 1 data. Combinational.
- `o_GRFReadData2_64`, out, 64: read port 2 data. Combinational.
- `o_Busy1`, out, 1: the register addressed by port 1 has a pending writer.
- `o_Busy2`, out, 1: the register addressed by port 2 has a pending writer.
- `i_WrEn`, in, 1: write-back valid.
- `i_WrAddr_5`, in, 5: write-back destination.
- `i_WrData_64`, in, 64: write-back data.
- `i_IssueEn`, in, 1: an instruction writing rd is issued this cycle.
- `i_IssueRd_5`, in, 5: rd of the issued instruction.

## Operation
- **Storage:** 31 physical registers, x1 to x31. A read of address 0 always returns 64'h0.
- **Write:** when `i_WrEn` is high and `i_WrAddr_5` ≠ 0, the register takes `i_WrData_64` at the clock edge. Writes to x0 are dropped silently.
- **Read:**
  - Combinational index of the array.
  - With `BYPASS_EN`=1, if `i_WrEn` is high and `i_WrAddr_5` equals the read address (≠0), the port returns `i_WrData_64`.
  - Both ports are independent; both may hit the bypass in the same cycle.
- **Scoreboard:** a 32-bit `busy` vector; bit 0 is constantly 0.
  - Set: `i_IssueEn` with `i_IssueRd_5` ≠ 0 sets `busy[rd]`.
  - Clear: `i_WrEn` with `i_WrAddr_5` ≠ 0 clears `busy[WrAddr]`.
  - Set and clear on the same register in the same cycle: set wins. The new writer is still pending.
  - Set and clear on different registers: both take effect.
- **Busy outputs:** `o_BusyN` = `busy[addrN]` & ~(`BYPASS_EN` & `i_WrEn` & `i_WrAddr_5`==addrN). A register being written back this cycle reads as not busy only when bypass is enabled.
- **Ordering:** one outstanding writer per register is the contract. A second issue to an already-busy rd keeps the bit set. The first write-back then clears it; issue logic must stall WAW.

## Timing
- **Read latency:** 0 cycles (combinational address to data).
- **Write latency:** data is stored at the edge where `i_WrEn` is high. It is visible on a non-bypassed read from the next cycle.
- **Scoreboard latency:** an issue in cycle N produces `o_Busy` high from cycle N+1. A write-back in cycle M produces busy low in cycle M with bypass, or in cycle M+1 without.
- **Reset values:**
  - `busy` = 0.
  - Registers = 0 if `RESET_CLEAR`.
  - `o_GRFReadData*` = 0 for any address when `RESET_CLEAR`=1.
  - `o_Busy*` = 0.
- **Reset mid-operation:** reset takes priority over a concurrent write or issue. Pending writers are forgotten. Write-backs arriving after reset just store data and clear an already-clear bit.

## Structure
- Shared package `grf_pkg` holds:
  - `XLEN` = 64 and `NREG` = 32.
  - The register-index type (5 bits).
  - The constant `REG_ZERO` = 5'd0.
- One sub-module, `grf_scoreboard`, holds the busy vector with set/clear/reset and two lookup ports. The data array and bypass muxes stay in the top module.

## Test plan
- **Reset and x0:** after reset, read x0..x31 → all 0. Write x0 = 64'hDEAD → read x0 = 0 and busy[0] = 0.
- **Write then read:** write x5 = 64'h0123_4567_89AB_CDEF. The next cycle reads the same value on both ports.
- **Bypass:** in the same cycle, write x7 = 64'h55 with port 1 reading x7. With `BYPASS_EN`=1 → 64'h55 and `o_Busy1`=0. With `BYPASS_EN`=0 → the old value (0).
- **Scoreboard:** issue rd = x3 in cycle 1 → `o_Busy2` = 1 for rs2 = x3 in cycles 2..4. Write-back x3 in cycle 5 → `o_Busy2` = 0 in cycle 5 (bypass on).
- **Simultaneous issue and write-back:** issue x9 and write-back x9 in the same cycle → busy[9] = 1 the next cycle and data = new value. Issue x10 and write-back x9 → busy[9] = 0 and busy[10] = 1.
- **Reset mid-operation:** set busy on x1, x2, x31, then assert `i_Rst` together with `i_IssueEn` on x4 → all busy = 0 and (with `RESET_CLEAR`=1) all registers = 0 the next cycle.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared types and constants for the integer register file.
package grf_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned NREG = 32;

   typedef logic [4:0] reg_idx_t;

   localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/grf_scoreboard.sv
// Per-register busy vector: set on issue, clear on write-back, two lookup ports.
module grf_scoreboard
   import grf_pkg::*;
(
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     set_en_i,
   input  reg_idx_t set_idx_i,
   input  logic     clr_en_i,
   input  reg_idx_t clr_idx_i,
   input  reg_idx_t look1_idx_i,
   input  reg_idx_t look2_idx_i,
   output logic     busy1_o,
   output logic     busy2_o
);

   logic [NREG-1:0] busy_q, busy_d;

   // Clear is applied before set so a new writer to the same register stays pending.
   always_comb begin
      busy_d = busy_q;
      if (clr_en_i && (clr_idx_i != REG_ZERO)) begin
         busy_d[clr_idx_i] = 1'b0;
      end
      if (set_en_i && (set_idx_i != REG_ZERO)) begin
         busy_d[set_idx_i] = 1'b1;
      end
      busy_d[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   always_comb begin
      busy1_o = busy_q[look1_idx_i];
      busy2_o = busy_q[look2_idx_i];
   end

endmodule

// File: rtl/grf_regfile.sv
// RV64I integer register file: 2 read ports, 1 write-back port, optional bypass,
// and a busy scoreboard for RAW hazard detection.
module grf_regfile
   import grf_pkg::*;
#(
   parameter int unsigned BYPASS_EN   = 1,
   parameter int unsigned RESET_CLEAR = 1
) (
   input  logic            i_Clk,
   input  logic            i_Rst,
   input  logic [4:0]      i_GRFReadAddr1_5,
   input  logic [4:0]      i_GRFReadAddr2_5,
   output logic [XLEN-1:0] o_GRFReadData1_64,
   output logic [XLEN-1:0] o_GRFReadData2_64,
   output logic            o_Busy1,
   output logic            o_Busy2,
   input  logic            i_WrEn,
   input  logic [4:0]      i_WrAddr_5,
   input  logic [XLEN-1:0] i_WrData_64,
   input  logic            i_IssueEn,
   input  logic [4:0]      i_IssueRd_5
);

   // x0 has no storage; reads of address 0 are forced to zero.
   logic [XLEN-1:0] regs_q [1:NREG-1];

   logic wr_valid;
   logic hit1, hit2;
   logic sb_busy1, sb_busy2;

   assign wr_valid = i_WrEn && (i_WrAddr_5 != REG_ZERO);

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         if (RESET_CLEAR != 0) begin
            for (int unsigned i = 1; i < NREG; i++) begin
               regs_q[i] <= '0;
            end
         end
      end else if (wr_valid) begin
         regs_q[i_WrAddr_5] <= i_WrData_64;
      end
   end

   always_comb begin
      hit1 = (BYPASS_EN != 0) && wr_valid && (i_WrAddr_5 == i_GRFReadAddr1_5);
      hit2 = (BYPASS_EN != 0) && wr_valid && (i_WrAddr_5 == i_GRFReadAddr2_5);

      o_GRFReadData1_64 = '0;
      if (hit1) begin
         o_GRFReadData1_64 = i_WrData_64;
      end else if (i_GRFReadAddr1_5 != REG_ZERO) begin
         o_GRFReadData1_64 = regs_q[i_GRFReadAddr1_5];
      end

      o_GRFReadData2_64 = '0;
      if (hit2) begin
         o_GRFReadData2_64 = i_WrData_64;
      end else if (i_GRFReadAddr2_5 != REG_ZERO) begin
         o_GRFReadData2_64 = regs_q[i_GRFReadAddr2_5];
      end

      // A register being written back this cycle is ready only if its value is forwarded.
      o_Busy1 = sb_busy1 & ~hit1;
      o_Busy2 = sb_busy2 & ~hit2;
   end

   grf_scoreboard u_scoreboard (
      .clk_i       (i_Clk),
      .rst_i       (i_Rst),
      .set_en_i    (i_IssueEn),
      .set_idx_i   (i_IssueRd_5),
      .clr_en_i    (i_WrEn),
      .clr_idx_i   (i_WrAddr_5),
      .look1_idx_i (i_GRFReadAddr1_5),
      .look2_idx_i (i_GRFReadAddr2_5),
      .busy1_o     (sb_busy1),
      .busy2_o     (sb_busy2)
   );

endmodule

// File: tb/tb_grf_regfile.sv
// Self-checking bench for grf_regfile: bypass, no-bypass and no-reset-clear instances.
module tb_grf_regfile;

   logic        clk;
   logic        rst;
   logic [4:0]  ra1, ra2, wa, ird;
   logic        we, ie;
   logic [63:0] wd;

   logic [63:0] rd1, rd2, rd1_nb, rd2_nb, rd1_nc, rd2_nc;
   logic        b1, b2, b1_nb, b2_nb, b1_nc, b2_nc;

   logic [63:0] exp_q [$];
   logic [63:0] want;
   int          n_vec = 0;
   int          n_err = 0;

   localparam logic [63:0] V5  = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] V9A = 64'hA5A5_0000_1111_9999;
   localparam logic [63:0] V9B = 64'h5A5A_FFFF_2222_7777;

   grf_regfile #(.BYPASS_EN(1), .RESET_CLEAR(1)) dut (
      .i_Clk(clk), .i_Rst(rst), .i_GRFReadAddr1_5(ra1), .i_GRFReadAddr2_5(ra2),
      .o_GRFReadData1_64(rd1), .o_GRFReadData2_64(rd2), .o_Busy1(b1), .o_Busy2(b2),
      .i_WrEn(we), .i_WrAddr_5(wa), .i_WrData_64(wd), .i_IssueEn(ie), .i_IssueRd_5(ird)
   );

   grf_regfile #(.BYPASS_EN(0), .RESET_CLEAR(1)) dut_nb (
      .i_Clk(clk), .i_Rst(rst), .i_GRFReadAddr1_5(ra1), .i_GRFReadAddr2_5(ra2),
      .o_GRFReadData1_64(rd1_nb), .o_GRFReadData2_64(rd2_nb), .o_Busy1(b1_nb),
      .o_Busy2(b2_nb), .i_WrEn(we), .i_WrAddr_5(wa), .i_WrData_64(wd), .i_IssueEn(ie),
      .i_IssueRd_5(ird)
   );

   grf_regfile #(.BYPASS_EN(1), .RESET_CLEAR(0)) dut_nc (
      .i_Clk(clk), .i_Rst(rst), .i_GRFReadAddr1_5(ra1), .i_GRFReadAddr2_5(ra2),
      .o_GRFReadData1_64(rd1_nc), .o_GRFReadData2_64(rd2_nc), .o_Busy1(b1_nc),
      .o_Busy2(b2_nc), .i_WrEn(we), .i_WrAddr_5(wa), .i_WrData_64(wd), .i_IssueEn(ie),
      .i_IssueRd_5(ird)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are sampled 4 units later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we  = 1'b0;
      wa  = 5'd0;
      wd  = 64'h0;
      ie  = 1'b0;
      ird = 5'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      ra1 = 5'd0;
      ra2 = 5'd0;
      tick();
      tick();
      rst = 1'b0;
      for (int a = 0; a < 32; a++) begin
         ra1 = 5'(a);
         ra2 = 5'(31 - a);
         exp_q.push_back(64'h0);
         exp_q.push_back(64'h0);
         exp_q.push_back(64'h0);
         exp_q.push_back(64'h0);
         #4;
         want = exp_q.pop_front(); n_vec++;
         if (rd1 !== want) begin
            n_err++; $display("FAIL reset_rd1 x%0d got %h want %h", a, rd1, want);
         end
         want = exp_q.pop_front(); n_vec++;
         if (rd2 !== want) begin
            n_err++; $display("FAIL reset_rd2 x%0d got %h want %h", 31 - a, rd2, want);
         end
         want = exp_q.pop_front(); n_vec++;
         if ({63'b0, b1} !== want) begin
            n_err++; $display("FAIL reset_busy1 x%0d got %b want %0d", a, b1, want);
         end
         want = exp_q.pop_front(); n_vec++;
         if (rd1_nb !== want) begin
            n_err++; $display("FAIL reset_rd1_nb x%0d got %h want %h", a, rd1_nb, want);
         end
         tick();
      end
   endtask

   task automatic test_x0();
      // Write and issue to x0 in the same cycle; neither may have an effect.
      we = 1'b1; wa = 5'd0; wd = 64'hDEAD; ie = 1'b1; ird = 5'd0;
      ra1 = 5'd0; ra2 = 5'd0;
      exp_q.push_back(64'h0);
      #4;
      want = exp_q.pop_front(); n_vec++;
      if (rd1 !== want) begin
         n_err++; $display("FAIL x0_bypass got %h want %h", rd1, want);
      end
      tick();
      idle();
      exp_q.push_back(64'h0);
      exp_q.push_back(64'h0);
      #4;
      want = exp_q.pop_front(); n_vec++;
      if (rd1 !== want) begin
         n_err++; $display("FAIL x0_read got %h want %h", rd1, want);
      end
      want = exp_q.pop_front(); n_vec++;
      if ({63'b0, b1} !== want) begin
         n_err++; $display("FAIL x0_busy got %b want %0d", b1, want);
      end
      tick();
   endtask

   task automatic test_write_read();
      we = 1'b1; wa = 5'd5; wd = V5;
      ra1 = 5'd1; ra2 = 5'd2;
      tick();
      idle();
      ra1 = 5'd5; ra2 = 5'd5;
      exp_q.push_back(V5);
      exp_q.push_back(V5);
      exp_q.push_back(V5);
      #4;
      want = exp_q.pop_front(); n_vec++;
      if (rd1 !== want) begin
         n_err++; $display("FAIL wr_rd1 got %h want %h", rd1, want);
      end
      want = exp_q.pop_front(); n_vec++;
      if (rd2 !== want) begin
         n_err++; $display("FAIL wr_rd2 got %h want %h", rd2, want);
      end
      want = exp_q.pop_front(); n_vec++;
      if (rd2_nb !== want) begin
         n_err++; $display("FAIL wr_rd2_nb got %h want %h", rd2_nb, want);
      end
      tick();
   endtask

   task automatic test_bypass();
      ie = 1'b1; ird = 5'd7;
      tick();
      idle();
      we = 1'b1; wa = 5'd7; wd = 64'h55;
      ra1 = 5'd7; ra2 = 5'd7;
      exp_q.push_back(64'h55);
      exp_q.push_back(64'h0);
      exp_q.push_back(64'h0);
      exp_q.push_back(64'h1);
      exp_q.push_back(64'h55);
      #4;
      want = exp_q.pop_front(); n_vec++;
      if (rd1 !== want) begin
         n_err++; $display("FAIL byp_rd1 got %h want %h", rd1, want);
      end
      want = exp_q.pop_front(); n_vec++;
      if ({63'b0, b1} !== want) begin
         n_err++; $display("FAIL byp_busy1 got %b want %0d", b1, want);
      end
      want = exp_q.pop_front(); n_vec++;
      if (rd1_nb !== want) begin
         n_err++; $display("FAIL nobyp_rd1 got %h want %h", rd1_nb, want);
      end
      want = exp_q.pop_front(); n_vec++;
      if ({63'b0, b1_nb} !== want) begin
         n_err++; $display("FAIL nobyp_busy1 got %b want %0d", b1_nb, want);
      end
      want = exp_q.pop_front(); n_vec++;
      if (rd2 !== want) begin
         n_err++; $display("FAIL byp_rd2 got %h want %h", rd2, want);
      end
      tick();
      idle();
      exp_q.push_back(64'h55);
      exp_q.push_back(64'h0);
      #4;
      want = exp_q.pop_front(); n_vec++;
      if (rd1_nb !== want) begin
         n_err++; $display("FAIL nobyp_after_rd1 got %h want %h", rd1_nb, want);
      end
      want = exp_q.pop_front(); n_vec++;
      if ({63'b0, b1_nb} !== want) begin
         n_err++; $display("FAIL nobyp_after_busy1 got %b want %0d", b1_nb, want);
      end
      tick();
   endtask

   task automatic test_scoreboard();
      ra1 = 5'd0; ra2 = 5'd3;
      ie = 1'b1; ird = 5'd3;
      tick();
      idle();
      for (int c = 2; c <= 4; c++) begin
         exp_q.push_back(64'h1);
         exp_q.push_back(64'h1);
         #4;
         want = exp_q.pop_front(); n_vec++;
         if ({63'b0, b2} !== want) begin
            n_err++; $display("FAIL sb_busy2 cycle%0d got %b want %0d", c, b2, want);
         end
         want = exp_q.pop_front(); n_vec++;
         if ({63'b0, b2_nb} !== want) begin
            n_err++; $display("FAIL sb_busy2_nb cycle%0d got %b want %0d", c, b2_nb, want);
         end
         tick();
      end
      we = 1'b1; wa = 5'd3; wd = 64'h33;
      exp_q.push_back(64'h0);
      exp_q.push_back(64'h1);
      #4;
      want = exp_q.pop_front(); n_vec++;
      if ({63'b0, b2} !== want) begin
         n_err++; $display("FAIL sb_wb_busy2 got %b want %0d", b2, want);
      end
      want = exp_q.pop_front(); n_vec++;
      if ({63'b0, b2_nb} !== want) begin
         n_err++; $display("FAIL sb_wb_busy2_nb got %b want %0d", b2_nb, want);
      end
      tick();
      idle();
      exp_q.push_back(64'h0);
      #4;
      want = exp_q.pop_front(); n_vec++;
      if ({63'b0, b2_nb} !== want) begin
         n_err++; $display("FAIL sb_after_busy2_nb got %b want %0d", b2_nb, want);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      ie = 1'b1; ird = 5'd9; we = 1'b1; wa = 5'd9; wd = V9A;
      tick();
      idle();
      ra1 = 5'd9; ra2 = 5'd10;
      exp_q.push_back(64'h1);
      exp_q.push_back(V9A);
      #4;
      want = exp_q.pop_front(); n_vec++;
      if ({63'b0, b1} !== want) begin
         n_err++; $display("FAIL same_busy9 got %b want %0d", b1, want);
      end
      want = exp_q.pop_front(); n_vec++;
      if (rd1 !== want) begin
         n_err++; $display("FAIL same_rd9 got %h want %h", rd1, want);
      end
      tick();
      ie = 1'b1; ird = 5'd10; we = 1'b1; wa = 5'd9; wd = V9B;
      tick();
      idle();
      exp_q.push_back(64'h0);
      exp_q.push_back(64'h1);
      exp_q.push_back(64'h0);
      exp_q.push_back(64'h1);
      exp_q.push_back(V9B);
      #4;
      want = exp_q.pop_front(); n_vec++;
      if ({63'b0, b1} !== want) begin
         n_err++; $display("FAIL diff_busy9 got %b want %0d", b1, want);
      end
      want = exp_q.pop_front(); n_vec++;
      if ({63'b0, b2} !== want) begin
         n_err++; $display("FAIL diff_busy10 got %b want %0d", b2, want);
      end
      want = exp_q.pop_front(); n_vec++;
      if ({63'b0, b1_nb} !== want) begin
         n_err++; $display("FAIL diff_busy9_nb got %b want %0d", b1_nb, want);
      end
      want = exp_q.pop_front(); n_vec++;
      if ({63'b0, b2_nb} !== want) begin
         n_err++; $display("FAIL diff_busy10_nb got %b want %0d", b2_nb, want);
      end
      want = exp_q.pop_front(); n_vec++;
      if (rd1 !== want) begin
         n_err++; $display("FAIL diff_rd9 got %h want %h", rd1, want);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [4:0] busy_regs [3];
      busy_regs[0] = 5'd1; busy_regs[1] = 5'd2; busy_regs[2] = 5'd31;
      for (int k = 0; k < 3; k++) begin
         ie = 1'b1; ird = busy_regs[k];
         tick();
      end
      idle();
      ra1 = 5'd31; ra2 = 5'd1;
      exp_q.push_back(64'h1);
      exp_q.push_back(64'h1);
      #4;
      want = exp_q.pop_front(); n_vec++;
      if ({63'b0, b1} !== want) begin
         n_err++; $display("FAIL pre_rst_busy31 got %b want %0d", b1, want);
      end
      want = exp_q.pop_front(); n_vec++;
      if ({63'b0, b2} !== want) begin
         n_err++; $display("FAIL pre_rst_busy1 got %b want %0d", b2, want);
      end
      tick();
      // Reset must win over the concurrent issue and write.
      rst = 1'b1; ie = 1'b1; ird = 5'd4; we = 1'b1; wa = 5'd6; wd = 64'hBAD;
      tick();
      rst = 1'b0;
      idle();
      for (int a = 0; a < 32; a++) begin
         ra1 = 5'(a);
         ra2 = 5'(a);
         exp_q.push_back(64'h0);
         exp_q.push_back(64'h0);
         exp_q.push_back(64'h0);
         #1;
         want = exp_q.pop_front(); n_vec++;
         if (rd1 !== want) begin
            n_err++; $display("FAIL mid_rst_rd x%0d got %h want %h", a, rd1, want);
         end
         want = exp_q.pop_front(); n_vec++;
         if ({63'b0, b1} !== want) begin
            n_err++; $display("FAIL mid_rst_busy x%0d got %b want %0d", a, b1, want);
         end
         want = exp_q.pop_front(); n_vec++;
         if ({63'b0, b2_nc} !== want) begin
            n_err++; $display("FAIL mid_rst_busy_nc x%0d got %b want %0d", a, b2_nc, want);
         end
      end
      // Without reset clearing, earlier data survives.
      ra1 = 5'd5;
      exp_q.push_back(V5);
      #1;
      want = exp_q.pop_front(); n_vec++;
      if (rd1_nc !== want) begin
         n_err++; $display("FAIL noclear_rd5 got %h want %h", rd1_nc, want);
      end
      tick();
      we = 1'b1; wa = 5'd1; wd = 64'hFEED;
      tick();
      idle();
      ra1 = 5'd1; ra2 = 5'd1;
      exp_q.push_back(64'hFEED);
      exp_q.push_back(64'h0);
      #4;
      want = exp_q.pop_front(); n_vec++;
      if (rd1_nb !== want) begin
         n_err++; $display("FAIL post_rst_rd1 got %h want %h", rd1_nb, want);
      end
      want = exp_q.pop_front(); n_vec++;
      if ({63'b0, b2_nb} !== want) begin
         n_err++; $display("FAIL post_rst_busy1 got %b want %0d", b2_nb, want);
      end
      tick();
   endtask

   initial begin
      rst = 1'b1;
      ra1 = 5'd0;
      ra2 = 5'd0;
      idle();
      test_reset();
      test_x0();
      test_write_read();
      test_bypass();
      test_scoreboard();
      test_back_to_back();
      test_reset_mid();
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
